// File: rtl/fft_bank_io.sv
// Frame buffer front/back end for a two-bank in-place FFT: loads a frame into parity-mapped banks,
// hands the banks to the engine, then streams results out. Optional macro FFT_BANK_IO_BITREV_OUT_EN.
module fft_bank_io #(
    parameter int length = 32,
    parameter int R      = 5
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [2*length-1:0] s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic [2*length-1:0] m_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                m_last,
    output logic [2*length-1:0] o_b0_data,
    output logic [2*length-1:0] o_b1_data,
    output logic [R-2:0]        o_b0_addr,
    output logic [R-2:0]        o_b1_addr,
    output logic                o_b0_w_en,
    output logic                o_b1_w_en,
    input  logic [2*length-1:0] i_b0_data,
    input  logic [2*length-1:0] i_b1_data,
    output logic                o_mem_own,
    output logic                o_load_done,
    input  logic                i_fft_done
);
    localparam int W = 2 * length;
    localparam logic [R-1:0] ONE_R  = 1;
    localparam logic [R:0]   ONE_R1 = 1;

    typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;
    state_t state, state_nxt;

    logic [R-1:0] wr_cnt;
    logic [R:0]   rd_cnt;
    logic [R-1:0] out_cnt;
    logic         vld_p1;
    logic         bank_p1;
    logic [W-1:0] fifo_mem [2];
    logic         fifo_wp;
    logic         fifo_rp;
    logic [1:0]   fifo_count;

    logic         load_hs;
    logic         out_hs;
    logic         rd_issue;
    logic [2:0]   occupancy;
    logic [R-1:0] rd_idx;
    logic [R-1:0] acc_idx;
    logic         acc_bank;

`ifdef FFT_BANK_IO_BITREV_OUT_EN
    function automatic logic [R-1:0] bitrev(input logic [R-1:0] k);
        logic [R-1:0] r;
        for (int i = 0; i < R; i++) r[i] = k[R-1-i];
        return r;
    endfunction

    assign rd_idx = bitrev(rd_cnt[R-1:0]);
`else
    assign rd_idx = rd_cnt[R-1:0];
`endif

    assign s_ready   = (state == LOAD);
    assign o_mem_own = (state != COMPUTE);
    assign load_hs   = (state == LOAD) && s_valid && !i_rst;

    assign m_valid = (fifo_count != 2'd0);
    assign m_data  = fifo_mem[fifo_rp];
    assign m_last  = m_valid && (&out_cnt);
    assign out_hs  = m_valid && m_ready;

    // Occupancy after this cycle's pop; lets a read issue every cycle while the consumer keeps up.
    assign occupancy = {1'b0, fifo_count} - {2'b0, out_hs} + {2'b0, vld_p1};
    assign rd_issue  = (state == UNLOAD) && !rd_cnt[R] && (occupancy < 3'd2) && !i_rst;

    assign acc_idx  = (state == UNLOAD) ? rd_idx : wr_cnt;
    assign acc_bank = ^acc_idx;

    assign o_b0_data = s_data;
    assign o_b1_data = s_data;

    always_comb begin
        o_b0_addr = '0;
        o_b1_addr = '0;
        o_b0_w_en = 1'b0;
        o_b1_w_en = 1'b0;
        if (load_hs || rd_issue) begin
            if (acc_bank) begin
                o_b1_addr = acc_idx[R-1:1];
                o_b1_w_en = load_hs;
            end else begin
                o_b0_addr = acc_idx[R-1:1];
                o_b0_w_en = load_hs;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (load_hs && (&wr_cnt)) state_nxt = COMPUTE;
            COMPUTE: if (i_fft_done) state_nxt = UNLOAD;
            UNLOAD:  if (out_hs && m_last) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    // Control state; wr_cnt wraps to zero on the final load handshake.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= LOAD;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            out_cnt     <= '0;
            vld_p1      <= 1'b0;
            fifo_count  <= 2'd0;
            fifo_wp     <= 1'b0;
            fifo_rp     <= 1'b0;
            o_load_done <= 1'b0;
        end else begin
            state       <= state_nxt;
            o_load_done <= load_hs && (&wr_cnt);
            if (load_hs) wr_cnt <= wr_cnt + ONE_R;
            vld_p1 <= rd_issue;
            if (rd_issue) rd_cnt <= rd_cnt + ONE_R1;
            if (vld_p1) fifo_wp <= ~fifo_wp;
            if (out_hs) begin
                fifo_rp <= ~fifo_rp;
                out_cnt <= out_cnt + ONE_R;
            end
            fifo_count <= fifo_count + {1'b0, vld_p1} - {1'b0, out_hs};
            if (out_hs && m_last) begin
                rd_cnt     <= '0;
                out_cnt    <= '0;
                vld_p1     <= 1'b0;
                fifo_count <= 2'd0;
                fifo_wp    <= 1'b0;
                fifo_rp    <= 1'b0;
            end
        end
    end

    // Read stage p1: bank data arrives one cycle after issue, steered by the bank recorded at issue.
    always_ff @(posedge i_clk) begin
        bank_p1 <= acc_bank;
        if (vld_p1) fifo_mem[fifo_wp] <= bank_p1 ? i_b1_data : i_b0_data;
    end

endmodule

// File: tb/tb_fft_bank_io.sv
// Randomized bench for fft_bank_io with a frame-level reference model and two behavioural banks.
module tb_fft_bank_io;
    localparam int LEN = 32;
    localparam int R   = 5;
    localparam int N   = 32;
    localparam int W   = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] s_data;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic         m_last;
    logic [W-1:0] b0_wd, b1_wd;
    logic [R-2:0] b0_addr, b1_addr;
    logic         b0_w_en, b1_w_en;
    logic [W-1:0] b0_rd, b1_rd;
    logic         mem_own;
    logic         load_done;
    logic         fft_done;

    int checks = 0;
    int errors = 0;
    bit hold_rdy = 0;

    logic [W-1:0] b0_mem [16];
    logic [W-1:0] b1_mem [16];

    always #5 clk = ~clk;

    fft_bank_io #(.length(LEN), .R(R)) dut (
        .i_clk(clk), .i_rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .o_b0_data(b0_wd), .o_b1_data(b1_wd),
        .o_b0_addr(b0_addr), .o_b1_addr(b1_addr),
        .o_b0_w_en(b0_w_en), .o_b1_w_en(b1_w_en),
        .i_b0_data(b0_rd), .i_b1_data(b1_rd),
        .o_mem_own(mem_own), .o_load_done(load_done), .i_fft_done(fft_done)
    );

    // Synchronous banks: write on w_en, registered read of the presented address.
    always @(posedge clk) begin
        if (b0_w_en) b0_mem[b0_addr] <= b0_wd;
        if (b1_w_en) b1_mem[b1_addr] <= b1_wd;
        b0_rd <= b0_mem[b0_addr];
        b1_rd <= b1_mem[b1_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int kmap(input int j);
        int r = 0;
`ifdef FFT_BANK_IO_BITREV_OUT_EN
        for (int i = 0; i < R; i++) if (j[i]) r = r | (1 << (R - 1 - i));
`else
        r = j;
`endif
        return r;
    endfunction

    // Reference model: phase, frame indices and stored samples, checked every cycle.
    initial begin
        int ph = 0;
        bit on = 0;
        int ld_idx = 0, out_idx = 0, ucyc = 0, p;
        bit ld_done_exp = 0;
        logic [W-1:0] loaded [N];
        forever begin
            @(negedge clk);
            if (on) begin
                check("s_ready", s_ready, ph == 0);
                check("mem_own", mem_own, ph != 1);
                check("load_done", load_done, ld_done_exp);
                check("b0_wdata", b0_wd, s_data);
                check("b1_wdata", b1_wd, s_data);
                if (ph == 0 && s_valid && !rst) begin
                    p = $countones(ld_idx) % 2;
                    check("wr_en_sel", p ? b1_w_en : b0_w_en, 1);
                    check("wr_en_oth", p ? b0_w_en : b1_w_en, 0);
                    check("wr_addr", p ? b1_addr : b0_addr, ld_idx >> 1);
                    check("wr_addr_oth", p ? b0_addr : b1_addr, 0);
                end else begin
                    check("no_write", {b1_w_en, b0_w_en}, 0);
                    if (ph != 2) check("idle_addr", {b1_addr, b0_addr}, 0);
                end
                if (ph != 2) begin
                    check("m_valid_idle", m_valid, 0);
                    check("m_last_idle", m_last, 0);
                end else begin
                    if (ucyc < 2) check("m_valid_early", m_valid, 0);
                    else if (ucyc == 2 || (hold_rdy && out_idx < N)) check("m_valid_on", m_valid, 1);
                    if (m_valid) begin
                        check("m_last", m_last, out_idx == N - 1);
                        if (m_ready && !rst) check("m_data", m_data, loaded[kmap(out_idx)]);
                    end else check("m_last_nv", m_last, 0);
                end
            end
            ld_done_exp = 0;
            if (rst) begin
                on = 1; ph = 0; ld_idx = 0; out_idx = 0;
            end else if (ph == 0) begin
                if (s_valid) begin
                    loaded[ld_idx] = s_data;
                    if (ld_idx == N - 1) begin
                        ph = 1; ld_idx = 0; ld_done_exp = 1;
                    end else ld_idx++;
                end
            end else if (ph == 1) begin
                if (fft_done) begin ph = 2; ucyc = 0; end
            end else begin
                ucyc++;
                if (m_valid && m_ready) begin
                    if (out_idx == N - 1) begin ph = 0; out_idx = 0; end
                    else out_idx++;
                end
            end
        end
    end

    task automatic load_frame(input bit pat, input int pct, input int pulse_cyc);
        int sent = 0, cyc = 0;
        while (sent < N && cyc < 2000) begin
            s_valid  = (pct >= 100) || ($urandom_range(99) < pct);
            s_data   = pat ? (64'h1000 + 64'(sent)) : {$urandom, $urandom};
            fft_done = (cyc == pulse_cyc);
            @(negedge clk);
            if (s_valid && s_ready) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        s_valid = 0; fft_done = 0;
        if (sent < N) check("load_timeout", sent, N);
    endtask

    task automatic unload(input int mode, input int rst_at, output logic [W-1:0] f0, output logic [W-1:0] f1);
        int got = 0, cyc = 0;
        f0 = '0; f1 = '0;
        hold_rdy = (mode == 0);
        m_ready  = (mode == 0);
        repeat (3) begin @(posedge clk); #1; end
        fft_done = 1;
        @(posedge clk); #1;
        fft_done = 0;
        while (got < N && cyc < 3000) begin
            if (mode == 0) m_ready = 1;
            else if (mode == 1) m_ready = (cyc < 12) ? !cyc[0] : (cyc >= 22);
            else m_ready = $urandom_range(1);
            @(negedge clk);
            if (mode == 1 && cyc >= 15 && cyc < 22) check("fifo_holds", m_valid, 1);
            if (m_valid && m_ready) begin
                if (got == 0) f0 = m_data;
                if (got == 1) f1 = m_data;
                got++;
            end
            @(posedge clk); #1;
            cyc++;
            if (rst_at >= 0 && got == rst_at) begin
                rst = 1; m_ready = 0;
                @(posedge clk); #1;
                rst = 0;
                @(negedge clk);
                check("rst_m_valid", m_valid, 0);
                check("rst_s_ready", s_ready, 1);
                @(posedge clk); #1;
                break;
            end
        end
        hold_rdy = 0;
        m_ready  = 0;
        if (rst_at < 0 && got < N) check("unload_timeout", got, N);
    endtask

    initial begin
        logic [W-1:0] f0, f1;
        rst = 1; s_valid = 0; s_data = '0; m_ready = 0; fft_done = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("rst_s_ready", s_ready, 1);
        check("rst_m_valid", m_valid, 0);
        check("rst_mem_own", mem_own, 1);
        check("rst_load_done", load_done, 0);
        @(posedge clk); #1;

        load_frame(1, 100, 10);
        check("mem_k0", b0_mem[0], 64'h1000);
        check("mem_k1", b1_mem[0], 64'h1001);
        check("mem_k3", b0_mem[1], 64'h1003);
        check("mem_k7", b1_mem[3], 64'h1007);
        check("mem_k30", b0_mem[15], 64'h101E);
        check("mem_k31", b1_mem[15], 64'h101F);
        unload(0, -1, f0, f1);
        check("out0", f0, 64'h1000);
`ifdef FFT_BANK_IO_BITREV_OUT_EN
        check("out1", f1, 64'h1010);
`else
        check("out1", f1, 64'h1001);
`endif

        load_frame(0, 50, -1);
        unload(1, -1, f0, f1);

        load_frame(0, 50, -1);
        unload(2, 17, f0, f1);

        load_frame(0, 70, 3);
        unload(2, -1, f0, f1);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
